// File: rtl/darkbus_init.sv
// darkbus initiator: turns core load/store requests into darkbus transactions,
// with lane steering, load extension, a bus timeout and a misalignment check.
module darkbus_init #(
   parameter int TIMEOUT = 255
) (
   input  logic        XCLK,
   input  logic        XRES,
   input  logic        REQ,
   input  logic        WR,
   input  logic [1:0]  SIZE,
   input  logic        SIGNED,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   output logic        READY,
   output logic        ACK,
   output logic        ERR,
   output logic [31:0] RDATA,
   output logic        BUS_EN,
   output logic        BUS_RW,
   output logic [3:0]  BUS_BE,
   output logic [31:0] BUS_ADDR,
   inout  wire  [31:0] BUS_DATA,
   input  logic        BUS_VALID
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_r;
   logic [CW-1:0] cnt_r;
   logic        ready_r;
   logic        ack_r;
   logic        err_r;
   logic [31:0] rdata_r;
   logic        bus_en_r;
   logic        bus_rw_r;
   logic [3:0]  bus_be_r;
   logic [31:0] bus_addr_r;
   logic [31:0] bus_wdata_r;
   logic [1:0]  size_r;
   logic        signed_r;
   logic [1:0]  addr_lo_r;

   logic        req_mis_s;
   logic [3:0]  req_be_s;
   logic [31:0] req_lanes_s;

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         2'd0:    return 1'b0;
         2'd1:    return lo[0];
         2'd2:    return (lo != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         2'd0:    return 4'b0001 << lo;
         2'd1:    return 4'b0011 << {lo[1], 1'b0};
         2'd2:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] write_lanes(input logic [1:0] sz, input logic [31:0] w);
      case (sz)
         2'd0:    return {4{w[7:0]}};
         2'd1:    return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
   function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] lo);
      logic [31:0] b_sh;
      logic [31:0] h_sh;
      b_sh = d >> {lo, 3'b000};
      h_sh = d >> {lo[1], 4'b0000};
      case (sz)
         2'd0:    return {{24{sg & b_sh[7]}}, b_sh[7:0]};
         2'd1:    return {{16{sg & h_sh[15]}}, h_sh[15:0]};
         default: return d;
      endcase
   endfunction

   // Decode the incoming request for the IDLE-state accept.
   always_comb begin
      req_mis_s   = is_misaligned(SIZE, ADDR[1:0]);
      req_be_s    = byte_enables(SIZE, ADDR[1:0]);
      req_lanes_s = write_lanes(SIZE, WDATA);
   end

   // Transaction FSM; every output comes straight from a register.
   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CW{1'b0}};
         ready_r     <= 1'b1;
         ack_r       <= 1'b0;
         err_r       <= 1'b0;
         rdata_r     <= 32'h0000_0000;
         bus_en_r    <= 1'b0;
         bus_rw_r    <= 1'b0;
         bus_be_r    <= 4'b0000;
         bus_addr_r  <= 32'h0000_0000;
         bus_wdata_r <= 32'h0000_0000;
         size_r      <= 2'd0;
         signed_r    <= 1'b0;
         addr_lo_r   <= 2'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ack_r   <= 1'b0;
               err_r   <= 1'b0;
               rdata_r <= 32'h0000_0000;
               if (REQ) begin
                  ready_r     <= 1'b0;
                  size_r      <= SIZE;
                  signed_r    <= SIGNED;
                  addr_lo_r   <= ADDR[1:0];
                  bus_rw_r    <= WR;
                  bus_be_r    <= req_be_s;
                  bus_addr_r  <= {ADDR[31:2], 2'b00};
                  bus_wdata_r <= req_lanes_s;
                  cnt_r       <= {CW{1'b0}};
                  if (req_mis_s) begin
                     state_r <= ST_RESP;
                     ack_r   <= 1'b1;
                     err_r   <= 1'b1;
                  end else begin
                     state_r  <= ST_BUS;
                     bus_en_r <= 1'b1;
                  end
               end
            end
            ST_BUS: begin
               // Valid takes priority over a timeout in the same cycle.
               if (BUS_VALID) begin
                  state_r  <= ST_RESP;
                  bus_en_r <= 1'b0;
                  ack_r    <= 1'b1;
                  err_r    <= 1'b0;
                  rdata_r  <= bus_rw_r ? 32'h0000_0000
                                       : extract(BUS_DATA, size_r, signed_r, addr_lo_r);
               end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                  state_r  <= ST_RESP;
                  bus_en_r <= 1'b0;
                  ack_r    <= 1'b1;
                  err_r    <= 1'b1;
                  rdata_r  <= 32'h0000_0000;
               end else if (cnt_r != CNT_MAX) begin
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_RESP: begin
               state_r  <= ST_IDLE;
               ack_r    <= 1'b0;
               err_r    <= 1'b0;
               rdata_r  <= 32'h0000_0000;
               ready_r  <= 1'b1;
               bus_rw_r <= 1'b0;
            end
            default: begin
               state_r  <= ST_IDLE;
               ready_r  <= 1'b1;
               ack_r    <= 1'b0;
               err_r    <= 1'b0;
               bus_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign READY    = ready_r;
   assign ACK      = ack_r;
   assign ERR      = err_r;
   assign RDATA    = rdata_r;
   assign BUS_EN   = bus_en_r;
   assign BUS_RW   = bus_rw_r;
   assign BUS_BE   = bus_be_r;
   assign BUS_ADDR = bus_addr_r;
   assign BUS_DATA = (bus_en_r && bus_rw_r) ? bus_wdata_r : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_darkbus_init.sv
// Bench for darkbus_init: directed vector table, reset corner case and
// randomized transactions checked against an arithmetic reference model.
module tb_darkbus_init;

   localparam int TO = 4;

   logic        xclk;
   logic        xres;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic        sg;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        ack;
   logic        err;
   logic [31:0] rdata;
   logic        bus_en;
   logic        bus_rw;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   wire  [31:0] bus_data;
   logic        bus_valid;
   logic [31:0] tb_bus_val;

   int checks;
   int failures;

   // Responder side drives the data bus whenever the initiator is not writing.
   assign bus_data = (bus_en && bus_rw) ? 32'hzzzz_zzzz : tb_bus_val;

   darkbus_init #(.TIMEOUT(TO)) dut (
      .XCLK(xclk), .XRES(xres), .REQ(req), .WR(wr), .SIZE(size), .SIGNED(sg),
      .ADDR(addr), .WDATA(wdata), .READY(ready), .ACK(ack), .ERR(err),
      .RDATA(rdata), .BUS_EN(bus_en), .BUS_RW(bus_rw), .BUS_BE(bus_be),
      .BUS_ADDR(bus_addr), .BUS_DATA(bus_data), .BUS_VALID(bus_valid)
   );

   initial xclk = 1'b0;
   always #5 xclk = ~xclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdat;
      int          vcyc;
      logic        mis;
      logic        err;
      logic [3:0]  be;
      logic [31:0] bdata;
      logic [31:0] rdata;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: byte-count arithmetic rather than case tables.
   task automatic model(input logic w, input logic [1:0] sz, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int vc, output vec_t v);
      int n;
      int off;
      longint lane;
      v.wr = w; v.size = sz; v.sg = s; v.addr = a; v.wdata = wd; v.rdat = rd; v.vcyc = vc;
      n = 1 << sz;
      off = int'(a % 4);
      v.mis = (sz == 2'd3) || ((a % n) != 0);
      v.err = v.mis || (vc < 1) || (vc > TO);
      v.be = 4'b0000;
      v.bdata = 32'h0;
      for (int j = 0; j < 4; j++) begin
         if (j >= off && j < off + n) v.be[j] = 1'b1;
         v.bdata[8*j +: 8] = wd[8*(j % n) +: 8];
      end
      if (n >= 4) begin
         lane = longint'(rd);
      end else begin
         lane = (longint'(rd) >> (8 * off)) % (64'sd1 <<< (8 * n));
         if (s && (lane >= (64'sd1 <<< (8 * n - 1)))) lane = lane - (64'sd1 <<< (8 * n));
      end
      v.rdata = v.err ? 32'h0 : lane[31:0];
   endtask

   task automatic txn(input string nm, input vec_t v);
      int c;
      bit done;
      chk({nm, " ready_before"}, {31'd0, ready}, 32'd1);
      req = 1'b1; wr = v.wr; size = v.size; sg = v.sg; addr = v.addr; wdata = v.wdata;
      @(posedge xclk); #1;
      req = 1'b0;
      if (v.mis) begin
         chk({nm, " mis_bus_en"}, {31'd0, bus_en}, 32'd0);
         chk({nm, " mis_ack"}, {31'd0, ack}, 32'd1);
         chk({nm, " mis_err"}, {31'd0, err}, 32'd1);
         chk({nm, " mis_rdata"}, rdata, 32'd0);
      end else begin
         c = 1;
         done = 1'b0;
         while (!done) begin
            chk({nm, " bus_en"}, {31'd0, bus_en}, 32'd1);
            chk({nm, " ack_low"}, {31'd0, ack}, 32'd0);
            chk({nm, " rw"}, {31'd0, bus_rw}, {31'd0, v.wr});
            chk({nm, " be"}, {28'd0, bus_be}, {28'd0, v.be});
            chk({nm, " baddr"}, bus_addr, {v.addr[31:2], 2'b00});
            if (v.wr) chk({nm, " bdata"}, bus_data, v.bdata);
            tb_bus_val = v.wr ? 32'h0 : v.rdat;
            bus_valid = (c == v.vcyc);
            if (c == v.vcyc || c >= TO) done = 1'b1;
            @(posedge xclk); #1;
            bus_valid = 1'b0;
            tb_bus_val = 32'h0;
            c++;
         end
         chk({nm, " ack"}, {31'd0, ack}, 32'd1);
         chk({nm, " ack_bus_en"}, {31'd0, bus_en}, 32'd0);
         chk({nm, " err"}, {31'd0, err}, {31'd0, v.err});
         if (!v.wr || v.err) chk({nm, " rdata"}, rdata, v.rdata);
         if (v.wr) chk({nm, " released"}, bus_data, 32'h0);
      end
      @(posedge xclk); #1;
      chk({nm, " ready_after"}, {31'd0, ready}, 32'd1);
      chk({nm, " ack_after"}, {31'd0, ack}, 32'd0);
      chk({nm, " rdata_after"}, rdata, 32'd0);
      chk({nm, " bus_en_after"}, {31'd0, bus_en}, 32'd0);
   endtask

   vec_t tbl[10];
   vec_t rv;

   initial begin
      checks = 0; failures = 0;
      xres = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; sg = 1'b0;
      addr = 32'h0; wdata = 32'h0; bus_valid = 1'b0; tb_bus_val = 32'h0;

      //            wr    size  sg    addr          wdata         rdat          vc mis   err   be       bdata         rdata
      tbl[0] = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        32'hA1B2_C3D4, 3, 1'b0, 1'b0, 4'b1111, 32'h0,        32'hA1B2_C3D4};
      tbl[1] = '{1'b0, 2'd0, 1'b1, 32'h4000_0003, 32'h0,        32'h80FF_FF7F, 1, 1'b0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
      tbl[2] = '{1'b0, 2'd0, 1'b0, 32'h4000_0003, 32'h0,        32'h80FF_FF7F, 2, 1'b0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
      tbl[3] = '{1'b1, 2'd1, 1'b0, 32'h4000_0002, 32'h0000_BEEF, 32'h0,        2, 1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
      tbl[4] = '{1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,        32'h1111_1111, 0, 1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
      tbl[5] = '{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,        32'h5555_AAAA, 0, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h0};
      tbl[6] = '{1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'h0,        32'h1234_5678, 4, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h1234_5678};
      tbl[7] = '{1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1, 1'b0, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
      tbl[8] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        1, 1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
      tbl[9] = '{1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_00AB, 32'h0,        1, 1'b0, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};

      repeat (2) @(posedge xclk);
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_bus_en", {31'd0, bus_en}, 32'd0);
      chk("rst_rw", {31'd0, bus_rw}, 32'd0);
      chk("rst_be", {28'd0, bus_be}, 32'd0);
      chk("rst_baddr", bus_addr, 32'd0);
      xres = 1'b1;
      @(posedge xclk); #1;

      for (int i = 0; i < 10; i++) txn($sformatf("vec%0d", i), tbl[i]);

      // Reset in the second bus cycle of a store.
      req = 1'b1; wr = 1'b1; size = 2'd2; sg = 1'b0; addr = 32'h0000_0008; wdata = 32'hCAFE_F00D;
      @(posedge xclk); #1;
      req = 1'b0;
      @(posedge xclk); #1;
      chk("midrst_pre_en", {31'd0, bus_en}, 32'd1);
      chk("midrst_pre_data", bus_data, 32'hCAFE_F00D);
      #2 xres = 1'b0;
      #1;
      chk("midrst_en", {31'd0, bus_en}, 32'd0);
      chk("midrst_data", bus_data, 32'h0);
      chk("midrst_ack", {31'd0, ack}, 32'd0);
      @(posedge xclk); #1;
      chk("midrst_ack2", {31'd0, ack}, 32'd0);
      xres = 1'b1;
      @(posedge xclk); #1;
      chk("midrst_ready", {31'd0, ready}, 32'd1);
      chk("midrst_ack3", {31'd0, ack}, 32'd0);
      model(1'b0, 2'd2, 1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_CAFE, 2, rv);
      txn("post_rst", rv);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra;
         ra = $urandom;
         model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ra, $urandom, $urandom, int'($urandom_range(0, TO + 1)), rv);
         txn($sformatf("rnd%0d", i), rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
